// File: rtl/timer_delay_datapath.sv
// Delay-load and interval-timing datapath for the programmable timer.
// Shifts a serial delay in MSB first, then counts (delay+1) units of TICKS_PER_UNIT cycles.
module timer_delay_datapath #(
  parameter int DELAY_W        = 4,
  parameter int TICKS_PER_UNIT = 1000,
  parameter int SUB_W          = $clog2(TICKS_PER_UNIT)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               data,
  input  logic               shift_ena,
  input  logic               counting,
  output logic [DELAY_W-1:0] count,
  output logic               done_counting,
  output logic               unit_tick
);

  localparam logic [SUB_W-1:0] SUB_LAST = SUB_W'(TICKS_PER_UNIT - 1);

  logic [DELAY_W-1:0] count_q, count_d;
  logic [SUB_W-1:0]   sub_q, sub_d;
  logic               unit_end;
  logic               active;

  assign unit_end = (sub_q == SUB_LAST);
  // Shift has priority over counting, so a simultaneous request never ticks.
  assign active        = counting & ~shift_ena & ~reset;
  assign unit_tick     = active & unit_end;
  assign done_counting = unit_tick & (count_q == '0);
  assign count         = count_q;

  always_comb begin
    count_d = count_q;
    sub_d   = '0;
    if (shift_ena) begin
      count_d = {count_q[DELAY_W-2:0], data};
    end else if (counting) begin
      if (unit_end) begin
        // Saturate at zero so a held counting input keeps pulsing without wrapping.
        if (count_q != '0) count_d = count_q - DELAY_W'(1);
      end else begin
        sub_d = sub_q + SUB_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count_q <= '0;
      sub_q   <= '0;
    end else begin
      count_q <= count_d;
      sub_q   <= sub_d;
    end
  end

endmodule

// File: doc/timer_delay_datapath.md
Name: timer_delay_datapath

Overview:
- Datapath stage directly downstream of the serial-start sequence FSM in the programmable-timer subsystem.
- Shift phase: while `shift_ena` is high, captures the 4-bit delay value from the serial `data` line, MSB first.
- Count phase: while `counting` is high, runs the timer for exactly (delay+1)*TICKS_PER_UNIT cycles.
- Returns `done_counting` to the FSM and exposes the remaining whole units on `count`.

Parameters:
- DELAY_W, 4: width of the delay/count register; number of shift_ena cycles per load.
- TICKS_PER_UNIT, 1000: clock cycles per time unit; must be >= 2.
- SUB_W, $clog2(TICKS_PER_UNIT): width of the intra-unit sub-counter.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  reset, synchronous, active-high.
- data  in  1  serial delay bits, sampled only when shift_ena=1.
- shift_ena  in  1  from FSM; shift data into count register this cycle.
- counting  in  1  from FSM; timer active this cycle.
- count  out  DELAY_W  remaining whole units (registered).
- done_counting  out  1  final cycle of the timed interval (Mealy, combinational from registers + counting).
- unit_tick  out  1  one-cycle pulse on the last cycle of each unit while counting.

Behaviour:

Reset (clk edge with reset=1):
- count=0 and sub=0.
- done_counting=0 and unit_tick=0 during the reset cycle; both are gated by !reset.
- Reset mid-shift or mid-count aborts immediately. No partial value is retained.

Shift (shift_ena=1):
- count <= {count[DELAY_W-2:0], data}. After 4 consecutive shift cycles, count holds the delay with the first bit as MSB.
- sub <= 0.
- Non-consecutive shift cycles still shift; the FSM owns framing.

Count (counting=1, shift_ena=0):
- sub increments each cycle.
- When sub==TICKS_PER_UNIT-1:
  - sub <= 0 and unit_tick=1.
  - If count!=0, count <= count-1.
  - If count==0, count holds at 0. It saturates and never wraps to all-ones.
- done_counting = counting & !shift_ena & (count==0) & (sub==TICKS_PER_UNIT-1).

Interval length:
- With counting asserted from cycle 0, done_counting is high in cycle (delay+1)*TICKS_PER_UNIT-1.
- The FSM samples it at that edge and leaves the count phase, giving exactly (delay+1)*TICKS_PER_UNIT counting cycles.
- Delay 0 gives 1 unit; delay 15 gives 16 units.

Counting held after done:
- If counting stays high after done, count stays 0.
- done_counting and unit_tick then pulse every TICKS_PER_UNIT cycles.

Idle (both inputs low):
- count holds; sub <= 0.
- A counting gap restarts the current unit from 0 without losing count.

Simultaneous shift_ena and counting:
- Protocol violation. Shift wins, sub <= 0, done_counting=0 and unit_tick=0.
- The bench flags this with an assertion; the RTL tolerates it deterministically.

Arithmetic:
- All unsigned. sub compares against TICKS_PER_UNIT-1 sized to SUB_W.

Latency:
- count updates one edge after the shift or tick event.
- done_counting has zero-cycle latency from the registered state.

Test Plan:
- TICKS_PER_UNIT=4: reset, shift 1,0,1,1 over 4 cycles -> count=4'hB after the 4th edge; done_counting stays 0 throughout.
- TICKS_PER_UNIT=4, delay=2, hold counting -> unit_tick at cycles 3, 7, 11; count goes 2->1->0; done_counting only in cycle 11 (12 cycles total).
- TICKS_PER_UNIT=4, delay=0 -> done_counting in cycle 3; keep counting high 8 more cycles -> count stays 0, done_counting pulses at cycles 7 and 11.
- Default 1000, delay=15, FSM model driving shift_ena/counting -> done_counting exactly 16000 cycles after counting rises; count observed 15..0 in order.
- TICKS_PER_UNIT=4, delay=3: counting 6 cycles, reset 1 cycle, then idle -> count=0, sub=0, done_counting=0; a fresh shift of 0001 then counting yields done at cycle 7.
- TICKS_PER_UNIT=4, delay=5: counting 2 cycles, drop counting 3 cycles, resume -> count still 5; the first unit_tick comes 4 cycles after the resume (sub was cleared).
